// File: rtl/retire_trace_pkg.sv
// Shared types and constants for the retire trace buffer: flag bit positions,
// default widths and the packed trace record stored in the FIFO.
package retire_trace_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_REG_SEL_W = 3;
  localparam int DEF_CNT_W     = 32;

  localparam int FLAG_W        = 4;
  localparam int FLAG_REGWRITE = 0;
  localparam int FLAG_MEMREAD  = 1;
  localparam int FLAG_MEMWRITE = 2;
  localparam int FLAG_HALT     = 3;

  // One retired instruction as seen by the trace consumer.
  typedef struct packed {
    logic [DEF_CNT_W-1:0]     inum;
    logic [DEF_DATA_W-1:0]    pc;
    logic [DEF_DATA_W-1:0]    inst;
    logic [DEF_REG_SEL_W-1:0] wreg;
    logic [DEF_DATA_W-1:0]    wdata;
    logic [DEF_DATA_W-1:0]    addr;
    logic [DEF_DATA_W-1:0]    mdata;
    logic [FLAG_W-1:0]        flags;
  } traceRec_t;

  // Gather the individual retire qualifiers into the flags nibble.
  function automatic logic [FLAG_W-1:0] packFlags(input logic regwrite,
                                                  input logic memread,
                                                  input logic memwrite,
                                                  input logic halt);
    logic [FLAG_W-1:0] f;
    f                = '0;
    f[FLAG_REGWRITE] = regwrite;
    f[FLAG_MEMREAD]  = memread;
    f[FLAG_MEMWRITE] = memwrite;
    f[FLAG_HALT]     = halt;
    return f;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous first-word-fall-through FIFO. The head word is held in a
// register so it reads 0 after reset and keeps its last value while empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] pushData,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] headData
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W:0]   wrPtr, rdPtr, wrPtrNext, rdPtrNext;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] headNext;
  logic             doPush, doPop;

  assign full   = (wrPtr[IDX_W-1:0] == rdPtr[IDX_W-1:0]) && (wrPtr[IDX_W] != rdPtr[IDX_W]);
  assign empty  = (wrPtr == rdPtr);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  // Next pointers and the word that will sit at the head after this edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    headNext  = headData;
    rdPtrNext = rdPtr + (IDX_W+1)'(doPop);
    wrPtrNext = wrPtr + (IDX_W+1)'(doPush);
    if (rdPtrNext != wrPtrNext) begin
      // If the old contents run out this cycle, the new head is the word being pushed.
      if (rdPtrNext == wrPtr) headNext = pushData;
      else                    headNext = mem[rdPtrNext[IDX_W-1:0]];
    end
  end

  // Pointer and head register update.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      headData <= '0;
    end else begin
      wrPtr    <= wrPtrNext;
      rdPtr    <= rdPtrNext;
      headData <= headNext;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the array is not reset; pointers alone define which entries are valid.
    if (doPush) mem[wrPtr[IDX_W-1:0]] <= pushData;
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// Retire-event recorder: tags each accepted retire with an instruction number
// and buffers it for a valid/ready consumer. Holds the halt, overflow, drop and
// cycle bookkeeping. Optional macro RETIRE_TRACE_NOP_FILTER_EN suppresses
// records for retires that neither write a register, store, nor halt.
module retire_trace_buffer
  import retire_trace_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int REG_SEL_W = DEF_REG_SEL_W,
  parameter int DEPTH     = 16,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ret_valid,
  input  logic [DATA_W-1:0]    ret_pc,
  input  logic [DATA_W-1:0]    ret_inst,
  input  logic                 ret_regwrite,
  input  logic [REG_SEL_W-1:0] ret_wreg,
  input  logic [DATA_W-1:0]    ret_wdata,
  input  logic                 ret_memread,
  input  logic                 ret_memwrite,
  input  logic [DATA_W-1:0]    ret_addr,
  input  logic [DATA_W-1:0]    ret_mdata,
  input  logic                 ret_halt,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [CNT_W-1:0]     rd_inum,
  output logic [DATA_W-1:0]    rd_pc,
  output logic [DATA_W-1:0]    rd_inst,
  output logic [DATA_W-1:0]    rd_wdata,
  output logic [DATA_W-1:0]    rd_addr,
  output logic [DATA_W-1:0]    rd_mdata,
  output logic [REG_SEL_W-1:0] rd_wreg,
  output logic [3:0]           rd_flags,
  output logic                 halted,
  output logic                 overflow,
  output logic [CNT_W-1:0]     drop_count,
  output logic [CNT_W-1:0]     cycle_count
);

  localparam int REC_W = $bits(traceRec_t);

  logic [CNT_W-1:0] inumCnt;
  logic             accept, keepRecord, wantPush, popFire, dropNow;
  logic             fifoFull, fifoEmpty;
  traceRec_t        pushRec, headRec;

  assign accept = ret_valid && !halted;

`ifdef RETIRE_TRACE_NOP_FILTER_EN
  assign keepRecord = ret_regwrite || ret_memwrite || ret_halt;
`else
  assign keepRecord = 1'b1;
`endif

  assign wantPush = accept && keepRecord;
  assign rd_valid = !fifoEmpty;
  assign popFire  = rd_valid && rd_ready;
  assign dropNow  = wantPush && fifoFull && !popFire;

  // Pack the retiring instruction into a trace record.
  always_comb begin
    pushRec       = '0;
    pushRec.inum  = inumCnt;
    pushRec.pc    = ret_pc;
    pushRec.inst  = ret_inst;
    pushRec.wreg  = ret_wreg;
    pushRec.wdata = ret_wdata;
    pushRec.addr  = ret_addr;
    pushRec.mdata = ret_mdata;
    pushRec.flags = packFlags(ret_regwrite, ret_memread, ret_memwrite, ret_halt);
  end

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) uFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (wantPush),
    .pop      (rd_ready),
    .pushData (pushRec),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .headData (headRec)
  );

  assign rd_inum  = headRec.inum;
  assign rd_pc    = headRec.pc;
  assign rd_inst  = headRec.inst;
  assign rd_wreg  = headRec.wreg;
  assign rd_wdata = headRec.wdata;
  assign rd_addr  = headRec.addr;
  assign rd_mdata = headRec.mdata;
  assign rd_flags = headRec.flags;

  // INUM allocation, sticky status and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      inumCnt     <= '0;
      halted      <= 1'b0;
      overflow    <= 1'b0;
      drop_count  <= '0;
      cycle_count <= '0;
    end else begin
      if (!(&cycle_count)) cycle_count <= cycle_count + CNT_W'(1);
      if (accept) begin
        // Dropped and filtered retires still consume a number.
        inumCnt <= inumCnt + CNT_W'(1);
        if (ret_halt) halted <= 1'b1;
      end
      if (dropNow) begin
        overflow <= 1'b1;
        if (!(&drop_count)) drop_count <= drop_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Self-checking bench for retire_trace_buffer (DEPTH=4). A queue-based model
// derived from the retire/drain rules predicts every visible output.
module tb_retire_trace_buffer;

  localparam int DATA_W    = 16;
  localparam int REG_SEL_W = 3;
  localparam int DEPTH     = 4;
  localparam int CNT_W     = 32;
  localparam int SNAP_W    = 1 + CNT_W + 5*DATA_W + REG_SEL_W + 4 + 2 + 2*CNT_W;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 ret_valid;
  logic [DATA_W-1:0]    ret_pc, ret_inst, ret_wdata, ret_addr, ret_mdata;
  logic                 ret_regwrite, ret_memread, ret_memwrite, ret_halt;
  logic [REG_SEL_W-1:0] ret_wreg;
  logic                 rd_valid, rd_ready;
  logic [CNT_W-1:0]     rd_inum;
  logic [DATA_W-1:0]    rd_pc, rd_inst, rd_wdata, rd_addr, rd_mdata;
  logic [REG_SEL_W-1:0] rd_wreg;
  logic [3:0]           rd_flags;
  logic                 halted, overflow;
  logic [CNT_W-1:0]     drop_count, cycle_count;

  always #5 clk = ~clk;

  retire_trace_buffer #(
    .DATA_W(DATA_W), .REG_SEL_W(REG_SEL_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_inst(ret_inst),
    .ret_regwrite(ret_regwrite), .ret_wreg(ret_wreg), .ret_wdata(ret_wdata),
    .ret_memread(ret_memread), .ret_memwrite(ret_memwrite),
    .ret_addr(ret_addr), .ret_mdata(ret_mdata), .ret_halt(ret_halt),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_inum(rd_inum),
    .rd_pc(rd_pc), .rd_inst(rd_inst), .rd_wdata(rd_wdata),
    .rd_addr(rd_addr), .rd_mdata(rd_mdata), .rd_wreg(rd_wreg),
    .rd_flags(rd_flags), .halted(halted), .overflow(overflow),
    .drop_count(drop_count), .cycle_count(cycle_count)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [CNT_W-1:0]     inum;
    logic [DATA_W-1:0]    pc, inst;
    logic [REG_SEL_W-1:0] wreg;
    logic [DATA_W-1:0]    wdata, addr, mdata;
    logic [3:0]           flags;
  } rec_t;

  rec_t             modelQ[$];
  rec_t             lastHead;
  logic [CNT_W-1:0] mInum, mDrop, mCycle;
  bit               mHalted, mOverflow;

  int nCompared   = 0;
  int nMismatched = 0;

  function automatic void model_reset();
    modelQ.delete();
    lastHead  = '{default: '0};
    mInum     = '0;
    mDrop     = '0;
    mCycle    = '0;
    mHalted   = 1'b0;
    mOverflow = 1'b0;
  endfunction

  // One clock of consumer/producer activity: the consumer takes the head first,
  // then the producer appends, so a full buffer with a pop accepts the push.
  function automatic void model_step();
    rec_t r;
    bit   keep;
    if (modelQ.size() != 0 && rd_ready) void'(modelQ.pop_front());
    if (ret_valid && !mHalted) begin
      r.inum  = mInum;
      r.pc    = ret_pc;
      r.inst  = ret_inst;
      r.wreg  = ret_wreg;
      r.wdata = ret_wdata;
      r.addr  = ret_addr;
      r.mdata = ret_mdata;
      r.flags = {ret_halt, ret_memwrite, ret_memread, ret_regwrite};
      mInum   = mInum + 1;
`ifdef RETIRE_TRACE_NOP_FILTER_EN
      keep = ret_regwrite || ret_memwrite || ret_halt;
`else
      keep = 1'b1;
`endif
      if (keep) begin
        if (modelQ.size() < DEPTH) modelQ.push_back(r);
        else begin
          mOverflow = 1'b1;
          if (mDrop != '1) mDrop = mDrop + 1;
        end
      end
      if (ret_halt) mHalted = 1'b1;
    end
    if (mCycle != '1) mCycle = mCycle + 1;
    if (modelQ.size() != 0) lastHead = modelQ[0];
  endfunction

  function automatic logic [SNAP_W-1:0] model_snap();
    return {(modelQ.size() != 0), lastHead.inum, lastHead.pc, lastHead.inst,
            lastHead.wreg, lastHead.wdata, lastHead.addr, lastHead.mdata,
            lastHead.flags, mHalted, mOverflow, mDrop, mCycle};
  endfunction

  function automatic logic [SNAP_W-1:0] dut_snap();
    return {rd_valid, rd_inum, rd_pc, rd_inst, rd_wreg, rd_wdata, rd_addr,
            rd_mdata, rd_flags, halted, overflow, drop_count, cycle_count};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    ret_valid = 1'b0;
    rd_ready  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // flags are {halt, memwrite, memread, regwrite}
  task automatic set_retire(input logic v, input logic [DATA_W-1:0] pc,
                            input logic [3:0] fl, input logic [DATA_W-1:0] addr,
                            input logic [DATA_W-1:0] mdata);
    ret_valid    = v;
    ret_pc       = pc;
    ret_inst     = DATA_W'($urandom);
    ret_wreg     = REG_SEL_W'($urandom);
    ret_wdata    = DATA_W'($urandom);
    ret_regwrite = fl[0];
    ret_memread  = fl[1];
    ret_memwrite = fl[2];
    ret_halt     = fl[3];
    ret_addr     = addr;
    ret_mdata    = mdata;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    nCompared++;
    if (dut_snap() !== model_snap()) begin
      nMismatched++;
      $display("FAIL reset_state: got %h want %h", dut_snap(), model_snap());
    end
    nCompared++;
    if ({rd_inum, rd_pc, rd_flags, cycle_count} !== '0) begin
      nMismatched++;
      $display("FAIL reset_zero: got inum=%h pc=%h flags=%b cyc=%0d want all 0",
               rd_inum, rd_pc, rd_flags, cycle_count);
    end
  endtask

  task automatic test_in_order();
    do_reset();
    rd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_retire(1'b1, DATA_W'(2*k), 4'b0001, '0, '0);
      tick();
      nCompared++;
      if (rd_valid !== 1'b1 || rd_inum !== CNT_W'(k) || rd_pc !== DATA_W'(2*k)) begin
        nMismatched++;
        $display("FAIL in_order_%0d: got valid=%b inum=%0d pc=%h want valid=1 inum=%0d pc=%h",
                 k, rd_valid, rd_inum, rd_pc, k, 2*k);
      end
    end
    ret_valid = 1'b0;
    tick();
    nCompared++;
    if (dut_snap() !== model_snap() || rd_valid !== 1'b0 || overflow !== 1'b0) begin
      nMismatched++;
      $display("FAIL in_order_drained: got %h want %h", dut_snap(), model_snap());
    end
  endtask

  task automatic test_overflow();
    logic [CNT_W-1:0] seen;
    do_reset();
    rd_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_retire(1'b1, DATA_W'(16'h0100 + 2*i), 4'b0001, '0, '0);
      tick();
    end
    nCompared++;
    if (overflow !== 1'b1 || drop_count !== CNT_W'(2) || rd_valid !== 1'b1) begin
      nMismatched++;
      $display("FAIL overflow_status: got ovf=%b drops=%0d valid=%b want ovf=1 drops=2 valid=1",
               overflow, drop_count, rd_valid);
    end
    ret_valid = 1'b0;
    rd_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      seen = rd_inum;
      nCompared++;
      if (rd_valid !== 1'b1 || seen !== CNT_W'(i)) begin
        nMismatched++;
        $display("FAIL overflow_drain_%0d: got valid=%b inum=%0d want valid=1 inum=%0d",
                 i, rd_valid, seen, i);
      end
      tick();
    end
    nCompared++;
    if (rd_valid !== 1'b0) begin
      nMismatched++;
      $display("FAIL overflow_empty: got valid=%b want 0", rd_valid);
    end
    rd_ready = 1'b0;
    set_retire(1'b1, 16'h0200, 4'b0001, '0, '0);
    tick();
    nCompared++;
    if (rd_inum !== CNT_W'(6) || dut_snap() !== model_snap()) begin
      nMismatched++;
      $display("FAIL overflow_next_inum: got inum=%0d want 6 (snap %h vs %h)",
               rd_inum, dut_snap(), model_snap());
    end
  endtask

  task automatic test_full_push_pop();
    int               nRec;
    logic [CNT_W-1:0] lastInum;
    do_reset();
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_retire(1'b1, DATA_W'(16'h0300 + 2*i), 4'b0001, '0, '0);
      tick();
    end
    set_retire(1'b1, 16'h0308, 4'b0001, '0, '0);
    rd_ready = 1'b1;
    tick();
    nCompared++;
    if (drop_count !== '0 || overflow !== 1'b0) begin
      nMismatched++;
      $display("FAIL full_pushpop_drop: got drops=%0d ovf=%b want 0 0", drop_count, overflow);
    end
    ret_valid = 1'b0;
    nRec      = 0;
    lastInum  = '1;
    for (int i = 0; i < 10; i++) begin
      if (rd_valid === 1'b1) begin
        nRec++;
        lastInum = rd_inum;
      end
      tick();
    end
    nCompared++;
    if (nRec != 4 || lastInum !== CNT_W'(4)) begin
      nMismatched++;
      $display("FAIL full_pushpop_occupancy: got records=%0d last_inum=%0d want 4 and 4",
               nRec, lastInum);
    end
  endtask

  task automatic test_halt();
    int               nRec;
    logic [3:0]       lastFlags;
    logic [DATA_W-1:0] lastPc;
    do_reset();
    rd_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_retire(1'b1, DATA_W'(16'h000C + 2*i), 4'b0001, '0, '0);
      tick();
    end
    set_retire(1'b1, 16'h0010, 4'b1000, '0, '0);
    tick();
    nCompared++;
    if (halted !== 1'b1) begin
      nMismatched++;
      $display("FAIL halt_set: got halted=%b want 1", halted);
    end
    for (int i = 0; i < 2; i++) begin
      set_retire(1'b1, DATA_W'(16'h0012 + 2*i), 4'b0001, '0, '0);
      tick();
    end
    nCompared++;
    if (dut_snap() !== model_snap()) begin
      nMismatched++;
      $display("FAIL halt_ignore: got %h want %h", dut_snap(), model_snap());
    end
    ret_valid = 1'b0;
    rd_ready  = 1'b1;
    nRec      = 0;
    lastFlags = '0;
    lastPc    = '0;
    for (int i = 0; i < 8; i++) begin
      if (rd_valid === 1'b1) begin
        nRec++;
        lastFlags = rd_flags;
        lastPc    = rd_pc;
      end
      tick();
    end
    nCompared++;
    if (nRec != 3 || lastFlags !== 4'b1000 || lastPc !== 16'h0010 || halted !== 1'b1) begin
      nMismatched++;
      $display("FAIL halt_drain: got records=%0d flags=%b pc=%h halted=%b want 3 1000 0010 1",
               nRec, lastFlags, lastPc, halted);
    end
  endtask

  task automatic test_store();
    do_reset();
    rd_ready = 1'b0;
    set_retire(1'b1, 16'h0020, 4'b0100, 16'h1234, 16'hBEEF);
    tick();
    nCompared++;
    if (rd_valid !== 1'b1 || rd_flags !== 4'b0100 || rd_addr !== 16'h1234 || rd_mdata !== 16'hBEEF) begin
      nMismatched++;
      $display("FAIL store_fields: got valid=%b flags=%b addr=%h mdata=%h want 1 0100 1234 beef",
               rd_valid, rd_flags, rd_addr, rd_mdata);
    end
  endtask

  task automatic test_nop_filter();
    logic [CNT_W-1:0] expInum;
    logic [3:0]       expFlags;
`ifdef RETIRE_TRACE_NOP_FILTER_EN
    expInum  = CNT_W'(1);
    expFlags = 4'b0001;
`else
    expInum  = CNT_W'(0);
    expFlags = 4'b0000;
`endif
    do_reset();
    rd_ready = 1'b0;
    set_retire(1'b1, 16'h0040, 4'b0000, '0, '0);
    tick();
    set_retire(1'b1, 16'h0042, 4'b0001, '0, '0);
    tick();
    nCompared++;
    if (rd_valid !== 1'b1 || rd_inum !== expInum || rd_flags !== expFlags || overflow !== 1'b0) begin
      nMismatched++;
      $display("FAIL nop_head: got inum=%0d flags=%b ovf=%b want inum=%0d flags=%b ovf=0",
               rd_inum, rd_flags, overflow, expInum, expFlags);
    end
    ret_valid = 1'b0;
    tick();
    nCompared++;
    if (dut_snap() !== model_snap()) begin
      nMismatched++;
      $display("FAIL nop_state: got %h want %h", dut_snap(), model_snap());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_retire(1'b1, DATA_W'(16'h0500 + 2*i), 4'b0111, 16'h00AA, 16'h5555);
      tick();
    end
    do_reset();
    nCompared++;
    if (dut_snap() !== model_snap() || rd_valid !== 1'b0) begin
      nMismatched++;
      $display("FAIL reset_mid: got %h want %h", dut_snap(), model_snap());
    end
  endtask

  task automatic test_random();
    int nPrinted = 0;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      set_retire($urandom_range(0, 99) < 65, DATA_W'($urandom),
                 {($urandom_range(0, 79) == 0), 3'($urandom)},
                 DATA_W'($urandom), DATA_W'($urandom));
      rd_ready = ($urandom_range(0, 99) < 45);
      tick();
      nCompared++;
      if (dut_snap() !== model_snap()) begin
        nMismatched++;
        if (nPrinted < 10) begin
          nPrinted++;
          $display("FAIL random_cyc_%0d: got %h want %h", cyc, dut_snap(), model_snap());
        end
      end
      if (mHalted && $urandom_range(0, 29) == 0) begin
        do_reset();
        nCompared++;
        if (dut_snap() !== model_snap()) begin
          nMismatched++;
          $display("FAIL random_reset_%0d: got %h want %h", cyc, dut_snap(), model_snap());
        end
      end
    end
  endtask

  initial begin
    set_retire(1'b0, '0, 4'b0000, '0, '0);
    rd_ready = 1'b0;
    rst      = 1'b1;
    test_reset();
    test_in_order();
    test_overflow();
    test_full_push_pop();
    test_halt();
    test_store();
    test_nop_filter();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
